// File: rtl/intr_arb_if.sv
// intr_arb_if: device request bus and CPU interrupt/vector handshake.
// master = requesters/CPU side (drives requests and cpu_ack),
// slave  = the arbiter (drives interrupt, vector, dev_ack).
interface intr_arb_if #(
  parameter int N_DEV = 4
);
  logic [N_DEV-1:0]   dev_interrupt;
  logic [3*N_DEV-1:0] dev_ipl;
  logic [8*N_DEV-1:0] dev_vector;
  logic [2:0]         cpu_ipl;
  logic               cpu_ack;
  logic               interrupt;
  logic [7:0]         vector;
  logic [N_DEV-1:0]   dev_ack;

  modport master (
    output dev_interrupt, dev_ipl, dev_vector, cpu_ipl, cpu_ack,
    input  interrupt, vector, dev_ack
  );

  modport slave (
    input  dev_interrupt, dev_ipl, dev_vector, cpu_ipl, cpu_ack,
    output interrupt, vector, dev_ack
  );
endinterface

// File: rtl/intr_arb.sv
// intr_arb: shares the CPU interrupt/vector input among N_DEV devices.
// Picks the highest eligible request level above cpu_ipl, presents one
// latched interrupt/vector pair, and pulses dev_ack to the winner on cpu_ack.
// Optional feature macro: INTR_ARB_RR_EN -- round-robin tie breaking among
// equal levels; when undefined, ties go to the lowest index.
module intr_arb #(
  parameter int N_DEV = 4
) (
  input  logic      clk,
  input  logic      reset,
  intr_arb_if.slave bus
);
  localparam int IW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    win_q, win_d;
  logic [2:0]       ipl_q, ipl_d;
  logic [7:0]       vector_q, vector_d;
  logic             interrupt_q, interrupt_d;
  logic [N_DEV-1:0] dev_ack_q, dev_ack_d;

  logic [N_DEV-1:0] elig;
  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  logic [2:0]       sel_ipl;
  logic             win_elig;

`ifdef INTR_ARB_RR_EN
  // Index where the next tie-breaking search starts (one past last acked).
  logic [IW-1:0]    ptr_q, ptr_d;
`endif

  // A request is eligible only above the CPU priority; level 0 never is.
  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_elig
    assign elig[gi] = bus.dev_interrupt[gi] && (bus.dev_ipl[3*gi +: 3] > bus.cpu_ipl);
  end

  // Latched winner stays valid while it requests and outranks the CPU.
  assign win_elig = bus.dev_interrupt[win_q] && (bus.cpu_ipl < ipl_q);

  // Winner search: strict '>' keeps the first candidate visited on ties.
  always_comb begin
    int idx;
    idx       = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_ipl   = '0;
    for (int k = 0; k < N_DEV; k++) begin
`ifdef INTR_ARB_RR_EN
      idx = int'(ptr_q) + k;
      if (idx >= N_DEV) idx = idx - N_DEV;
`else
      idx = k;
`endif
      if (elig[idx] && (!sel_valid || (bus.dev_ipl[3*idx +: 3] > sel_ipl))) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(idx);
        sel_ipl   = bus.dev_ipl[3*idx +: 3];
      end
    end
  end

  // Next-state logic; winner/vector/level are latched only on leaving IDLE.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ipl_d    = ipl_q;
    vector_d = vector_q;
`ifdef INTR_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d  = S_REQ;
          win_d    = sel_idx;
          ipl_d    = sel_ipl;
          vector_d = bus.dev_vector[8*int'(sel_idx) +: 8];
        end
      end
      S_REQ: begin
        // An ack in the same cycle as a retract condition takes precedence.
        if (bus.cpu_ack)    state_d = S_ACK;
        else if (!win_elig) state_d = S_IDLE;
      end
      S_ACK: begin
        state_d = S_HOLD;
`ifdef INTR_ARB_RR_EN
        ptr_d = (win_q == IW'(N_DEV - 1)) ? '0 : win_q + 1'b1;
`endif
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop cleanly.
  always_comb begin
    interrupt_d = (state_d == S_REQ);
    dev_ack_d   = '0;
    if (state_d == S_ACK) dev_ack_d[win_d] = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      ipl_q       <= '0;
      vector_q    <= '0;
      interrupt_q <= 1'b0;
      dev_ack_q   <= '0;
`ifdef INTR_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ipl_q       <= ipl_d;
      vector_q    <= vector_d;
      interrupt_q <= interrupt_d;
      dev_ack_q   <= dev_ack_d;
`ifdef INTR_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.interrupt = interrupt_q;
  assign bus.vector    = vector_q;
  assign bus.dev_ack   = dev_ack_q;
endmodule

// File: tb/tb_intr_arb.sv
// tb_intr_arb: scripted scoreboard bench for intr_arb (N_DEV=4).
// Each cycle the driver pushes the expected outputs, then the monitor pops
// and compares them after the clock edge.
module tb_intr_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intr_arb_if #(.N_DEV(N)) bus ();
  intr_arb #(.N_DEV(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string      tag;
    bit         ei;
    int         ev;   // negative: vector not checked
    logic [3:0] ea;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dev(input int i, input bit req, input logic [2:0] ipl, input logic [7:0] vec);
    bus.dev_interrupt[i]    = req;
    bus.dev_ipl[3*i +: 3]   = ipl;
    bus.dev_vector[8*i +: 8] = vec;
  endtask

  task automatic cyc(input string tag, input bit ei, input int ev, input logic [3:0] ea);
    exp_t e;
    e.tag = tag; e.ei = ei; e.ev = ev; e.ea = ea;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      $display("txn %s: int=%0b vec=%o ack=%b", e.tag, bus.interrupt, bus.vector, bus.dev_ack);
      check_eq({e.tag, ".int"}, 32'(bus.interrupt), 32'(e.ei));
      check_eq({e.tag, ".ack"}, 32'(bus.dev_ack), 32'(e.ea));
      if (e.ev >= 0) check_eq({e.tag, ".vec"}, 32'(bus.vector), e.ev);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_dev(i, 1'b0, 3'd0, 8'd0);
  endtask

  initial begin
    logic [3:0] tie_ack [3];
    int         tie_vec [3];
`ifdef INTR_ARB_RR_EN
    tie_ack = '{4'b0001, 4'b0010, 4'b0001};
    tie_vec = '{8, 16, 8};
`else
    tie_ack = '{4'b0001, 4'b0001, 4'b0001};
    tie_vec = '{8, 8, 8};
`endif
    bus.cpu_ack = 1'b0;
    bus.cpu_ipl = 3'd0;
    clear_all();

    // Reset with every device requesting at level 7.
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_dev(i, 1'b1, 3'd7, 8'(8'o4 + 8'(4*i)));
    for (int c = 0; c < 3; c++) cyc("reset", 1'b0, 0, 4'b0000);
    reset = 1'b0;
    cyc("reset_release", 1'b1, 8'o4, 4'b0000);
    clear_all();
    cyc("reset_retract", 1'b0, -1, 4'b0000);

    // Basic request / ack / quiet period.
    set_dev(2, 1'b1, 3'd6, 8'o100);
    cyc("basic_req", 1'b1, 8'o100, 4'b0000);
    cyc("basic_hold", 1'b1, 8'o100, 4'b0000);
    bus.cpu_ack = 1'b1;
    cyc("basic_ack", 1'b0, -1, 4'b0100);
    bus.cpu_ack = 1'b0;
    set_dev(2, 1'b0, 3'd6, 8'o100);
    cyc("basic_q1", 1'b0, -1, 4'b0000);
    cyc("basic_q2", 1'b0, -1, 4'b0000);

    // Priority against cpu_ipl.
    bus.cpu_ipl = 3'd5;
    set_dev(0, 1'b1, 3'd4, 8'o60);
    set_dev(3, 1'b1, 3'd6, 8'o220);
    cyc("prio_hi", 1'b1, 8'o220, 4'b0000);
    bus.cpu_ack = 1'b1;
    cyc("prio_ack", 1'b0, -1, 4'b1000);
    bus.cpu_ack = 1'b0;
    set_dev(3, 1'b0, 3'd6, 8'o220);
    bus.cpu_ipl = 3'd3;
    cyc("prio_hold", 1'b0, -1, 4'b0000);
    cyc("prio_idle", 1'b0, -1, 4'b0000);
    cyc("prio_lo", 1'b1, 8'o60, 4'b0000);
    bus.cpu_ipl = 3'd4;
    cyc("prio_eq_retract", 1'b0, -1, 4'b0000);
    clear_all();
    bus.cpu_ipl = 3'd0;
    cyc("prio_clear", 1'b0, -1, 4'b0000);

    // Retract on cpu_ipl raise, re-present on lower, then ack beats retract.
    set_dev(1, 1'b1, 3'd5, 8'o64);
    cyc("ret_req", 1'b1, 8'o64, 4'b0000);
    bus.cpu_ipl = 3'd5;
    cyc("ret_drop", 1'b0, -1, 4'b0000);
    cyc("ret_idle", 1'b0, -1, 4'b0000);
    bus.cpu_ipl = 3'd4;
    cyc("ret_again", 1'b1, 8'o64, 4'b0000);
    bus.cpu_ack = 1'b1;
    set_dev(1, 1'b0, 3'd5, 8'o64);
    cyc("ackwin_ack", 1'b0, -1, 4'b0010);
    bus.cpu_ack = 1'b0;
    bus.cpu_ipl = 3'd0;
    cyc("ackwin_hold", 1'b0, -1, 4'b0000);
    cyc("ackwin_idle", 1'b0, -1, 4'b0000);

    // cpu_ack with nothing pending is ignored; level 0 is never eligible.
    set_dev(2, 1'b1, 3'd0, 8'o44);
    bus.cpu_ack = 1'b1;
    cyc("stray_ack", 1'b0, -1, 4'b0000);
    bus.cpu_ack = 1'b0;
    cyc("lvl0", 1'b0, -1, 4'b0000);
    clear_all();

    // Tie at level 5, requests held through three acks.
    set_dev(0, 1'b1, 3'd5, 8'o10);
    set_dev(1, 1'b1, 3'd5, 8'o20);
    for (int n = 0; n < 3; n++) begin
      cyc($sformatf("tie%0d_req", n), 1'b1, tie_vec[n], 4'b0000);
      bus.cpu_ack = 1'b1;
      cyc($sformatf("tie%0d_ack", n), 1'b0, -1, tie_ack[n]);
      bus.cpu_ack = 1'b0;
      cyc($sformatf("tie%0d_hold", n), 1'b0, -1, 4'b0000);
      cyc($sformatf("tie%0d_idle", n), 1'b0, -1, 4'b0000);
    end

    // Reset while presenting, with cpu_ack high: everything cleared.
    cyc("pre_rst_req", 1'b1, -1, 4'b0000);
    reset = 1'b1;
    bus.cpu_ack = 1'b1;
    cyc("rst_in_req", 1'b0, 0, 4'b0000);
    bus.cpu_ack = 1'b0;
    cyc("rst_in_req2", 1'b0, 0, 4'b0000);
    reset = 1'b0;
    cyc("rst_after", 1'b1, 8'o10, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
